// File: rtl/fetch_sequencer_rv.sv
// Single-issue fetch and sequencing stage feeding the ALU execute block.
// Owns the architectural PC. Fetches one instruction word over a valid/ready
// request and valid-only response interface, then classifies the opcode.
// It presents the instruction to execute and holds it until alu_done.
// On alu_done it advances to next_pc (redirect) or pc+4.
// An unsupported opcode or a misaligned next PC parks the block in HALT.
// Only reset leaves HALT.
//
// All outputs come straight from registers. The request valid is a register
// too, so it reads 0 in the cycle after reset, like every other valid. The
// first request appears one cycle later. A handshake is therefore only taken
// when the registered valid and imem_req_ready are both high.

module fetch_sequencer_rv #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned INSTRET_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  // instruction memory request
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_addr,
  // instruction memory response
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  // execute stage interface
  output logic [31:0]              instruction,
  output logic                     instruction_valid,
  output logic [31:0]              pc,
  output logic                     register_type_alu,
  output logic                     immediate_type_alu,
  output logic                     control_type,
  input  logic                     alu_done,
  input  logic                     next_pc_valid,
  input  logic [31:0]              next_pc,
  // status
  output logic                     illegal_instruction,
  output logic                     misaligned_fault,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic                     halted
);

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXECUTE,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    CLASS_NONE,
    CLASS_REG,
    CLASS_IMM,
    CLASS_CTRL
  } op_class_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Every piece of architectural state lives in one record. The FSM is then
  // a single register process plus a single next-value process.
  typedef struct packed {
    state_t                   state;
    logic                     req_valid;
    logic [31:0]              pc;
    logic [31:0]              instruction;
    logic                     instr_valid;
    logic                     reg_alu;
    logic                     imm_alu;
    logic                     ctrl;
    logic                     illegal;
    logic                     misaligned;
    logic                     halted;
    logic [INSTRET_WIDTH-1:0] instret;
  } seq_regs_t;

  seq_regs_t cur;
  seq_regs_t nxt;

  op_class_t   resp_class;
  logic [31:0] seq_pc;
  logic [31:0] target_pc;

  // Map an opcode onto the execute-stage class it belongs to.
  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_REG:    cls = CLASS_REG;
      OP_IMM:    cls = CLASS_IMM;
      OP_BRANCH,
      OP_JAL,
      OP_JALR,
      OP_LUI,
      OP_AUIPC:  cls = CLASS_CTRL;
      default:   cls = CLASS_NONE;
    endcase
    return cls;
  endfunction

  assign resp_class = classify(imem_resp_data[6:0]);
  // The 32-bit sum wraps naturally, so 32'hFFFF_FFFC advances to 0.
  assign seq_pc     = cur.pc + 32'd4;
  assign target_pc  = next_pc_valid ? next_pc : seq_pc;

  // State register: a synchronous reset wins in every state and drops any
  // transaction that is still in flight.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the statement order.
    if (reset) begin
      cur       <= '0;
      cur.state <= FETCH_REQ;
      cur.pc    <= RESET_PC;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state and next-output logic for the four sequencing states.
  always_comb begin
    // NOTE: start from the current record so that every field has a value on
    // every path. A field missed in some branch would otherwise infer a latch.
    nxt = cur;

    unique case (cur.state)
      FETCH_REQ: begin
        // Keep the request and address stable until it is accepted.
        nxt.req_valid = 1'b1;
        if (cur.req_valid && imem_req_ready) begin
          nxt.req_valid = 1'b0;
          nxt.state     = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          nxt.instruction = imem_resp_data;
          if (resp_class == CLASS_NONE) begin
            nxt.illegal = 1'b1;
            nxt.halted  = 1'b1;
            nxt.state   = HALT;
          end else begin
            nxt.reg_alu     = (resp_class == CLASS_REG);
            nxt.imm_alu     = (resp_class == CLASS_IMM);
            nxt.ctrl        = (resp_class == CLASS_CTRL);
            nxt.instr_valid = 1'b1;
            nxt.state       = EXECUTE;
          end
        end
      end

      EXECUTE: begin
        if (alu_done) begin
          // A retire counts even when it then faults on its next PC.
          nxt.instret     = cur.instret + INSTRET_WIDTH'(1);
          nxt.instr_valid = 1'b0;
          nxt.reg_alu     = 1'b0;
          nxt.imm_alu     = 1'b0;
          nxt.ctrl        = 1'b0;
          if (target_pc[1:0] != 2'b00) begin
            // The PC keeps the faulting instruction's address for debug.
            nxt.misaligned = 1'b1;
            nxt.halted     = 1'b1;
            nxt.state      = HALT;
          end else begin
            nxt.pc        = target_pc;
            nxt.req_valid = 1'b1;
            nxt.state     = FETCH_REQ;
          end
        end
      end

      HALT: begin
        // Parked until reset; every input is ignored.
      end

      default: begin
        nxt.state = HALT;
      end
    endcase
  end

  assign imem_req_valid      = cur.req_valid;
  assign imem_addr           = cur.pc;
  assign instruction         = cur.instruction;
  assign instruction_valid   = cur.instr_valid;
  assign pc                  = cur.pc;
  assign register_type_alu   = cur.reg_alu;
  assign immediate_type_alu  = cur.imm_alu;
  assign control_type        = cur.ctrl;
  assign illegal_instruction = cur.illegal;
  assign misaligned_fault    = cur.misaligned;
  assign instret             = cur.instret;
  assign halted              = cur.halted;

endmodule
